// File: rtl/rf_pkg.sv
// Shared regfile write-port definitions: widths and the arbiter state encoding.
package rf_pkg;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/rf_dec5to32.sv
// 5-to-32 one-hot address decoder for the regfile write port.
module rf_dec5to32
  import rf_pkg::*;
(
  input  logic [RF_ADDR_W-1:0]   addr,
  output logic [RF_NUM_REGS-1:0] onehot
);
  assign onehot = RF_NUM_REGS'(1) << addr;
endmodule

// File: rtl/rf_rr_pick.sv
// Round-robin pick: first set request searching upward from last+1 with wrap.
module rf_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant
);
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin writeback arbiter with burst locking feeding a registered regfile write port.
// Optional RF_WR_ARB_ZERO_DROP_EN suppresses the write enable for register 0 writes.
module regfile_write_arbiter
  import rf_pkg::*;
#(
  parameter int N         = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic [N-1:0]           req_valid,
  input  logic [N-1:0]           req_lock,
  input  logic [RF_ADDR_W*N-1:0] req_reg,
  input  logic [RF_DATA_W*N-1:0] req_data,
  output logic [N-1:0]           req_ready,
  output logic                   ctrl_writeEnable,
  output logic [RF_ADDR_W-1:0]   ctrl_writeReg,
  output logic [RF_DATA_W-1:0]   data_writeReg,
  output logic [RF_NUM_REGS-1:0] write_onehot,
  output logic                   lock_active
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  arb_state_t           state, state_n;
  logic [IDX_W-1:0]     owner, owner_n, last, last_n, g;
  logic [3:0]           burst, burst_n;
  logic                 we_n, xfer;
  logic [RF_ADDR_W-1:0] wreg_n;
  logic [RF_DATA_W-1:0] wdata_n;
  logic [N-1:0]         rr_grant;
  logic [RF_NUM_REGS-1:0] dec;

  rf_rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req   (req_valid),
    .last  (last),
    .grant (rr_grant)
  );

  always_comb begin
    req_ready = '0;
    if (!ctrl_reset)
      req_ready = (state == LOCKED) ? (req_valid & (N'(1) << owner)) : rr_grant;
    xfer = |req_ready;
    g    = '0;
    for (int i = 0; i < N; i++)
      if (req_ready[i]) g = IDX_W'(i);
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    burst_n = burst;
    we_n    = 1'b0;
    wreg_n  = ctrl_writeReg;
    wdata_n = data_writeReg;
    if (xfer) begin
      last_n  = g;
      wreg_n  = req_reg[int'(g)*RF_ADDR_W +: RF_ADDR_W];
      wdata_n = req_data[int'(g)*RF_DATA_W +: RF_DATA_W];
`ifdef RF_WR_ARB_ZERO_DROP_EN
      we_n    = (wreg_n != '0);
`else
      we_n    = 1'b1;
`endif
      // Lock continues only while the burst budget allows another grant
      if (req_lock[g] && (({1'b0, burst} + 5'd1) < 5'(MAX_BURST))) begin
        state_n = LOCKED;
        owner_n = g;
        burst_n = burst + 4'd1;
      end else begin
        state_n = IDLE;
        burst_n = '0;
      end
    end else if (state == LOCKED) begin
      state_n = IDLE;
      burst_n = '0;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state            <= IDLE;
      owner            <= '0;
      last             <= IDX_W'(N-1);
      burst            <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      state            <= state_n;
      owner            <= owner_n;
      last             <= last_n;
      burst            <= burst_n;
      ctrl_writeEnable <= we_n;
      ctrl_writeReg    <= wreg_n;
      data_writeReg    <= wdata_n;
    end
  end

  rf_dec5to32 u_dec (.addr(ctrl_writeReg), .onehot(dec));

  assign write_onehot = dec & {RF_NUM_REGS{ctrl_writeEnable}};
  assign lock_active  = (state == LOCKED);
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port among N writeback requesters, for example the ALU, multdiv and the crane I/O unit. A round-robin arbiter picks one requester per cycle and lets a requester lock the port for short bursts. The winning write goes into a registered write-port stage that drives the regfile's write controls and a one-hot write-select vector.

## Interface
- N, 3: number of requesters (2..8)
- MAX_BURST, 4: maximum consecutive grants under lock (1..15)
- clock  in  1  rising-edge clock
- ctrl_reset  in  1  asynchronous, active-high reset
- req_valid  in  N  requester i has a write pending
- req_lock  in  N  requester i asks to keep the port after this transfer
- req_reg  in  5N  target register, slice [5i+4:5i]
- req_data  in  32N  write data, slice [32i+31:32i]
- req_ready  out  N  one-hot grant; transfer when req_valid[i] and req_ready[i]
- ctrl_writeEnable  out  1  regfile write enable
- ctrl_writeReg  out  5  regfile write address
- data_writeReg  out  32  regfile write data
- write_onehot  out  32  decoded ctrl_writeReg, all zero when ctrl_writeEnable is 0
- lock_active  out  1  state is LOCKED

## Operation
- State: state (IDLE or LOCKED), owner (index), last (last granted index), burst (4-bit count).
- Reset values: all outputs 0; state IDLE; last = N-1; burst = 0.
- IDLE:
  - Grant the first requester with valid set, searching from (last+1) mod N upward with wrap-around.
  - No request: req_ready = 0.
- LOCKED:
  - Only owner can be granted.
  - req_ready[owner] = req_valid[owner]; all other ready bits are 0.
- Each transfer by requester g:
  - last <= g.
  - Write stage loads reg and data; ctrl_writeEnable <= 1.
- Transfer with req_lock[g] = 1 and burst+1 < MAX_BURST: state <= LOCKED, owner <= g, burst <= burst+1.
- Transfer with req_lock[g] = 0, or burst+1 == MAX_BURST: state <= IDLE, burst <= 0. Lock is forcibly released.
- LOCKED with req_valid[owner] = 0: state <= IDLE, burst <= 0. No grant that cycle; normal arbitration resumes next cycle.
- No transfer in a cycle: ctrl_writeEnable <= 0. ctrl_writeReg and data_writeReg hold their values.
- write_onehot = decode(ctrl_writeReg) AND ctrl_writeEnable.
- ctrl_reset asserted mid-burst: all state and outputs clear immediately. A write that was in flight is dropped.

## Timing
- req_ready is combinational from req_valid, state, owner and last. It is forced to 0 while ctrl_reset = 1.
- Latency: a transfer in cycle t appears on the write port in cycle t+1 for exactly one cycle.
- Throughput: one write per cycle.
- Fairness:
  - With all N requesters valid and none locking, each is granted once per N cycles.
  - Worst-case wait is (N-1)·MAX_BURST cycles.
- req_reg and req_data must stay stable while req_valid is high and the transfer has not yet happened.

## Configuration
- Macro: RF_WR_ARB_ZERO_DROP_EN.
- Defined:
  - A transfer to register 0 is accepted normally: it gets ready, updates last and counts toward burst.
  - The next cycle has ctrl_writeEnable = 0 and write_onehot = 0.
  - ctrl_writeReg and data_writeReg still update.
- Undefined: register 0 writes pass through with ctrl_writeEnable = 1. The regfile discards them.

## Structure
- Shared package rf_pkg:
  - RF_ADDR_W = 5, RF_DATA_W = 32, RF_NUM_REGS = 32.
  - Enum arb_state_t {IDLE, LOCKED}.
- Sub-module rf_rr_pick: N-bit request vector plus last index in; one-hot grant out; combinational rotate-and-priority.
- write_onehot comes from an instance of the existing 5-to-32 decoder, gated by ctrl_writeEnable.

## Test plan
- Reset: assert ctrl_reset with all req_valid = 1.
  - req_ready = 0; all outputs 0.
  - After release, first grant goes to requester 0.
- Round-robin: N = 3, all valid, no lock, req_reg = {7, 5, 3} for requesters 0..2.
  - Grants 0, 1, 2, 0 in successive cycles.
  - ctrl_writeReg = 3, 5, 7, 3 one cycle later; write_onehot = 0x8, 0x20, 0x80, 0x8.
- Lock burst: requester 1 holds req_lock = 1 with requesters 0 and 2 also valid; MAX_BURST = 4.
  - Exactly 4 consecutive grants to requester 1, then requester 2 is granted.
- Lock drop: requester 2 locks, then deasserts req_valid in the next cycle.
  - lock_active falls; no grant that cycle; requester 0 is granted the following cycle.
- Zero write: requester 0 writes reg 0, data 0xDEADBEEF.
  - With RF_WR_ARB_ZERO_DROP_EN: ctrl_writeEnable = 0 and write_onehot = 0 next cycle.
  - Without it: ctrl_writeEnable = 1 and write_onehot = 0x1.
- Mid-burst reset: pulse ctrl_reset during the 2nd locked grant.
  - ctrl_writeEnable = 0 immediately; lock_active = 0.
  - Next grant after release goes to requester 0.
